joypad_hub: RTL and testbench

Parametrised successor to the two-port `controller` block. It drives and samples up to `P_ports` Sega-style 3-button pads through a shared mode-toggle scan sequencer. Each port decodes the pad into an NES-order button byte and detects pad presence. Each port also serves the CPU GPIO path with NES strobe/shift semantics, independently per port. It sits between the pad pins and the core's `O_GPIO_*` and `I_GPIO_*` ports.

---
 rtl/joypad_pkg.sv | 49 ++++
 rtl/joypad_port.sv | 76 +++++++
 rtl/joypad_hub.sv | 80 ++++++++
 tb/tb_joypad_hub.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/joypad_pkg.sv
// Shared definitions for the Sega 3-button pad hub: scan states, NES button
// order and raw pin positions.
package joypad_pkg;

  typedef enum logic [1:0] {
    S_HI_SETTLE,
    S_HI_SAMPLE,
    S_LO_SETTLE,
    S_LO_SAMPLE
  } scan_state_t;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // Mode = 1 pin meanings
  localparam int unsigned PIN_UP    = 0;
  localparam int unsigned PIN_DOWN  = 1;
  localparam int unsigned PIN_LEFT  = 2;
  localparam int unsigned PIN_RIGHT = 3;
  localparam int unsigned PIN_B     = 4;
  localparam int unsigned PIN_C     = 5;
  // Mode = 0 pin meanings; ID pins read low when a 3-button pad is attached
  localparam int unsigned PIN_ID0   = 2;
  localparam int unsigned PIN_ID1   = 3;
  localparam int unsigned PIN_A     = 4;
  localparam int unsigned PIN_START = 5;

  function automatic logic [7:0] assemble_buttons(input logic [5:0] hi,
                                                  input logic [5:0] lo);
    logic [7:0] b;
    b             = '0;
    b[BTN_A]      = ~lo[PIN_A];
    b[BTN_B]      = ~hi[PIN_B];
    b[BTN_SELECT] = ~hi[PIN_C];
    b[BTN_START]  = ~lo[PIN_START];
    b[BTN_UP]     = ~hi[PIN_UP];
    b[BTN_DOWN]   = ~hi[PIN_DOWN];
    b[BTN_LEFT]   = ~hi[PIN_LEFT];
    b[BTN_RIGHT]  = ~hi[PIN_RIGHT];
    return b;
  endfunction

endpackage

// File: rtl/joypad_port.sv
// One pad port: pin synchroniser, two-phase capture, presence/commit and the
// NES-style strobe/shift register serving the CPU GPIO path.
module joypad_port
  import joypad_pkg::*;
#(
  parameter int   P_sync_stages = 2,
  parameter logic P_fill        = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_pins,
  input  logic       i_hi_sample,
  input  logic       i_lo_sample,
  input  logic       i_load,
  input  logic       i_rden,
  output logic       o_data,
  output logic [7:0] o_buttons,
  output logic       o_present
);

  logic [5:0] r_sync [P_sync_stages];
  logic [5:0] r_hi;
  logic [7:0] r_buttons;
  logic       r_present;
  logic [7:0] r_sh;
  logic       r_rden_q;

  logic [5:0] w_pins;
  logic       w_present;
  logic       w_rden_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < P_sync_stages; i++) r_sync[i] <= '1;
    end else begin
      r_sync[0] <= i_pins;
      for (int unsigned i = 1; i < P_sync_stages; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_pins      = r_sync[P_sync_stages-1];
  assign w_present   = ~w_pins[PIN_ID0] & ~w_pins[PIN_ID1];
  assign w_rden_rise = i_rden & ~r_rden_q;

  // LO_SAMPLE both checks presence and commits, using the HI half captured earlier
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi      <= '1;
      r_buttons <= '0;
      r_present <= 1'b0;
    end else begin
      if (i_hi_sample) r_hi <= w_pins;
      if (i_lo_sample) begin
        r_present <= w_present;
        r_buttons <= w_present ? assemble_buttons(r_hi, w_pins) : '0;
      end
    end
  end

  // Load level has priority over a coincident read edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh     <= '0;
      r_rden_q <= 1'b0;
    end else begin
      r_rden_q <= i_rden;
      if (i_load)           r_sh <= r_buttons;
      else if (w_rden_rise) r_sh <= {P_fill, r_sh[7:1]};
    end
  end

  assign o_data    = r_sh[0];
  assign o_buttons = r_buttons;
  assign o_present = r_present;

endmodule

// File: rtl/joypad_hub.sv
// Multi-port Sega 3-button pad hub: one shared mode-toggle scan sequencer
// driving a generated array of pad ports.
module joypad_hub
  import joypad_pkg::*;
#(
  parameter int   P_ports       = 2,
  parameter int   P_sync_stages = 2,
  parameter int   P_scan_div    = 64,
  parameter logic P_fill        = 1'b1
) (
  input  logic                 I_clock,
  input  logic                 I_reset,
  input  logic [6*P_ports-1:0] I_joy_bits,
  output logic [P_ports-1:0]   O_joy_mode,
  input  logic [P_ports-1:0]   I_GPIO_load,
  input  logic [P_ports-1:0]   I_GPIO_rden,
  output logic [P_ports-1:0]   O_GPIO_data,
  output logic [8*P_ports-1:0] O_buttons,
  output logic [P_ports-1:0]   O_present
);

  localparam int CW = (P_scan_div > 1) ? $clog2(P_scan_div) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(P_scan_div - 1);

  scan_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_mode;
  logic          w_hi_sample;
  logic          w_lo_sample;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_state <= S_HI_SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_HI_SETTLE:
        if (r_cnt == CNT_LAST) w_state_nxt = S_HI_SAMPLE;
        else                   w_cnt_nxt   = r_cnt + CW'(1);
      S_HI_SAMPLE: w_state_nxt = S_LO_SETTLE;
      S_LO_SETTLE:
        if (r_cnt == CNT_LAST) w_state_nxt = S_LO_SAMPLE;
        else                   w_cnt_nxt   = r_cnt + CW'(1);
      S_LO_SAMPLE: w_state_nxt = S_HI_SETTLE;
      default:     w_state_nxt = S_HI_SETTLE;
    endcase
  end

  assign w_mode      = (r_state == S_HI_SETTLE) || (r_state == S_HI_SAMPLE);
  assign w_hi_sample = (r_state == S_HI_SAMPLE);
  assign w_lo_sample = (r_state == S_LO_SAMPLE);
  assign O_joy_mode  = {P_ports{w_mode}};

  for (genvar g = 0; g < P_ports; g++) begin : g_port
    joypad_port #(
      .P_sync_stages(P_sync_stages),
      .P_fill       (P_fill)
    ) u_port (
      .i_clk      (I_clock),
      .i_rst_n    (I_reset),
      .i_pins     (I_joy_bits[6*g +: 6]),
      .i_hi_sample(w_hi_sample),
      .i_lo_sample(w_lo_sample),
      .i_load     (I_GPIO_load[g]),
      .i_rden     (I_GPIO_rden[g]),
      .o_data     (O_GPIO_data[g]),
      .o_buttons  (O_buttons[8*g +: 8]),
      .o_present  (O_present[g])
    );
  end

endmodule

// File: tb/tb_joypad_hub.sv
// Self-checking bench for joypad_hub: two ports, short scan divider, a pad
// model that answers the mode line, and a queue of expected observations.
module tb_joypad_hub;

  localparam int P = 2;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6*P-1:0] joy;
  logic [P-1:0]  mode, load, rden, data, present;
  logic [8*P-1:0] buttons;
  logic [5:0]    hi_pat [P];
  logic [5:0]    lo_pat [P];

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  always_comb begin
    joy = '1;
    for (int n = 0; n < P; n++) joy[6*n +: 6] = mode[n] ? hi_pat[n] : lo_pat[n];
  end

  joypad_hub #(
    .P_ports      (P),
    .P_sync_stages(2),
    .P_scan_div   (D),
    .P_fill       (1'b1)
  ) dut (
    .I_clock    (clk),
    .I_reset    (rst_n),
    .I_joy_bits (joy),
    .O_joy_mode (mode),
    .I_GPIO_load(load),
    .I_GPIO_rden(rden),
    .O_GPIO_data(data),
    .O_buttons  (buttons),
    .O_present  (present)
  );

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pad(input int p, input logic [5:0] hi, input logic [5:0] lo);
    hi_pat[p] = hi;
    lo_pat[p] = lo;
  endtask

  task automatic load_pulse(input logic [1:0] m);
    @(negedge clk); load = m;
    @(negedge clk);
    @(negedge clk); load = 2'b00;
  endtask

  task automatic read_pulse(input logic [1:0] m, output logic [1:0] d);
    @(negedge clk); rden = m;
    #1 d = data;
    @(negedge clk); rden = 2'b00;
  endtask

  task automatic test_reset;
    logic [15:0] e;
    set_pad(0, 6'h3f, 6'h3f);
    set_pad(1, 6'h3f, 6'h3f);
    @(negedge clk); rst_n = 1'b0;
    #1;
    exp_q.push_back({2'b00, 2'b11, 2'b00, 2'b00, 8'h00});
    e = exp_q.pop_front(); n_cmp++;
    if ({2'b00, mode, present, data, buttons[7:0]} !== e || buttons !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state got mode=%b pres=%b data=%b btn=%h exp mode=11 pres=00 data=00 btn=0000",
               mode, present, data, buttons);
    end
    ticks(2);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      exp_q.push_back(16'(((k % 10) < 5) ? 2'b11 : 2'b00));
      e = exp_q.pop_front(); n_cmp++;
      if (16'(mode) !== e) begin
        n_err++;
        $display("FAIL mode_cycle%0d got %b exp %b", k, mode, e[1:0]);
      end
      if (k == 10) begin
        n_cmp++;
        if (present !== 2'b00 || buttons !== 16'h0000) begin
          n_err++;
          $display("FAIL absent_commit got pres=%b btn=%h exp pres=00 btn=0000", present, buttons);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_a_right;
    logic [1:0] d;
    logic [15:0] e;
    set_pad(0, 6'b110111, 6'b100011);
    ticks(30);
    n_cmp++;
    if (buttons[7:0] !== 8'h81 || present !== 2'b01) begin
      n_err++;
      $display("FAIL a_right_commit got btn=%h pres=%b exp btn=81 pres=01", buttons[7:0], present);
    end
    load_pulse(2'b01);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back((i == 0 || i >= 7) ? 16'd1 : 16'd0);
      read_pulse(2'b01, d);
      e = exp_q.pop_front(); n_cmp++;
      if (16'(d[0]) !== e) begin
        n_err++;
        $display("FAIL a_right_read%0d got %b exp %b", i, d[0], e[0]);
      end
    end
  endtask

  task automatic test_load_high;
    logic [1:0] d;
    logic [15:0] e;
    set_pad(0, 6'b111111, 6'b100011);
    ticks(30);
    n_cmp++;
    if (buttons[7:0] !== 8'h01) begin
      n_err++;
      $display("FAIL a_only_commit got %h exp 01", buttons[7:0]);
    end
    @(negedge clk); load = 2'b01;
    ticks(2);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'd1);
      read_pulse(2'b01, d);
      e = exp_q.pop_front(); n_cmp++;
      if (16'(d[0]) !== e) begin
        n_err++;
        $display("FAIL load_high_read%0d got %b exp %b", i, d[0], e[0]);
      end
    end
    @(negedge clk); load = 2'b00;
  endtask

  task automatic test_mid_read;
    logic [1:0] d;
    logic [15:0] e;
    bit exp_bits [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    set_pad(0, 6'b110111, 6'b100011);
    ticks(30);
    load_pulse(2'b01);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        set_pad(0, 6'b111111, 6'b110011);
        ticks(30);
        n_cmp++;
        if (buttons[7:0] !== 8'h00 || present[0] !== 1'b1) begin
          n_err++;
          $display("FAIL mid_read_commit got btn=%h pres=%b exp btn=00 pres=1", buttons[7:0], present[0]);
        end
      end
      exp_q.push_back(16'(exp_bits[i]));
      read_pulse(2'b01, d);
      e = exp_q.pop_front(); n_cmp++;
      if (16'(d[0]) !== e) begin
        n_err++;
        $display("FAIL mid_read%0d got %b exp %b", i, d[0], e[0]);
      end
    end
  endtask

  task automatic test_independence;
    logic [1:0] d;
    logic [15:0] e;
    logic [7:0] b0;
    set_pad(0, 6'b111111, 6'b010011);
    set_pad(1, 6'h3f, 6'h3f);
    ticks(30);
    n_cmp++;
    if (present !== 2'b01 || buttons !== 16'h0008) begin
      n_err++;
      $display("FAIL indep_commit got pres=%b btn=%h exp pres=01 btn=0008", present, buttons);
    end
    load_pulse(2'b11);
    b0 = 8'h08;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({14'd0, (i < 8) ? 1'b0 : 1'b1, (i < 8) ? b0[i] : 1'b1});
      read_pulse(2'b11, d);
      e = exp_q.pop_front(); n_cmp++;
      if (16'(d) !== e) begin
        n_err++;
        $display("FAIL indep_read%0d got p1p0=%b exp %b", i, d, e[1:0]);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [1:0] d;
    logic [15:0] e;
    logic [7:0] b;
    set_pad(0, 6'b110111, 6'b010011);
    ticks(30);
    load_pulse(2'b01);
    b = 8'h88;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'(b[i]));
      read_pulse(2'b01, d);
      e = exp_q.pop_front(); n_cmp++;
      if (16'(d[0]) !== e) begin
        n_err++;
        $display("FAIL pre_reset_read%0d got %b exp %b", i, d[0], e[0]);
      end
    end
    n_cmp++;
    if (data[0] !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_data got %b exp 1", data[0]);
    end
    ticks(7);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (data !== 2'b00 || mode !== 2'b11 || present !== 2'b00 || buttons !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset got data=%b mode=%b pres=%b btn=%h exp 00 11 00 0000",
               data, mode, present, buttons);
    end
    ticks(2);
    rst_n = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      #1;
      if (k == 9 || k == 10) begin
        exp_q.push_back((k == 10) ? 16'h0188 : 16'h0000);
        e = exp_q.pop_front(); n_cmp++;
        if ({7'd0, present[0], buttons[7:0]} !== e) begin
          n_err++;
          $display("FAIL restart_commit_c%0d got pres=%b btn=%h exp pres=%b btn=%h",
                   k, present[0], buttons[7:0], e[8], e[7:0]);
        end
      end
      if (k < 10) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    load  = '0;
    rden  = '0;
    set_pad(0, 6'h3f, 6'h3f);
    set_pad(1, 6'h3f, 6'h3f);
    test_reset();
    test_a_right();
    test_load_high();
    test_mid_read();
    test_independence();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
